// File: rtl/condicionador_entradas.sv
// Input conditioning for the game: 2-flop synchronizers, shared switch debounce
// and a button FSM producing press, level and long-press events.
module condicionador_entradas #(
    parameter int DEB_MAX  = 250000,
    parameter int LONG_MAX = 100000000,
    parameter int N_CH     = 8
) (
    input  logic            clock_in,
    input  logic            reset_n,
    input  logic [N_CH-1:0] ch_raw,
    input  logic            btn_raw,
    output logic [N_CH-1:0] ch_out,
    output logic            ch_mudou,
    output logic            btn_nivel,
    output logic            btn_pulso,
    output logic            btn_longo
);

    localparam int DW = $clog2(DEB_MAX);
    localparam int HW = $clog2(LONG_MAX);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_MAX - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_MAX - 1);

    typedef enum logic [2:0] {
        SOLTO, CONF_PRESS, PRESSIONADO, LONGO, CONF_SOLTA
    } estado_e;

    logic [N_CH-1:0] ch_meta_q, s_ch_q, s_ch_ant_q;
    logic [N_CH-1:0] ch_out_q, ch_out_d;
    logic [DW-1:0]   cnt_ch_q, cnt_ch_d, cnt_ch_inc;
    logic            ch_mudou_q, ch_mudou_d;

    logic            btn_meta_q, s_btn_q, p;
    estado_e         estado_q, estado_d;
    logic [DW-1:0]   cnt_b_q, cnt_b_d, cnt_b_inc;
    logic [HW-1:0]   cnt_h_q, cnt_h_d;
    logic            longo_emitido_q, longo_emitido_d;
    logic            btn_nivel_q, btn_nivel_d;
    logic            btn_pulso_q, btn_pulso_d;
    logic            btn_longo_q, btn_longo_d;

    assign p = ~s_btn_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the button chain resets to 1 because the pin idles released.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            ch_meta_q       <= '0;
            s_ch_q          <= '0;
            s_ch_ant_q      <= '0;
            ch_out_q        <= '0;
            cnt_ch_q        <= '0;
            ch_mudou_q      <= 1'b0;
            btn_meta_q      <= 1'b1;
            s_btn_q         <= 1'b1;
            estado_q        <= SOLTO;
            cnt_b_q         <= '0;
            cnt_h_q         <= '0;
            longo_emitido_q <= 1'b0;
            btn_nivel_q     <= 1'b0;
            btn_pulso_q     <= 1'b0;
            btn_longo_q     <= 1'b0;
        end else begin
            ch_meta_q       <= ch_raw;
            s_ch_q          <= ch_meta_q;
            s_ch_ant_q      <= s_ch_q;
            ch_out_q        <= ch_out_d;
            cnt_ch_q        <= cnt_ch_d;
            ch_mudou_q      <= ch_mudou_d;
            btn_meta_q      <= btn_raw;
            s_btn_q         <= btn_meta_q;
            estado_q        <= estado_d;
            cnt_b_q         <= cnt_b_d;
            cnt_h_q         <= cnt_h_d;
            longo_emitido_q <= longo_emitido_d;
            btn_nivel_q     <= btn_nivel_d;
            btn_pulso_q     <= btn_pulso_d;
            btn_longo_q     <= btn_longo_d;
        end
    end

    // Debounce accepts on the edge the count would reach DEB_MAX-1, giving
    // a total latency of 2+DEB_MAX edges from the first sampling edge.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        ch_out_d   = ch_out_q;
        ch_mudou_d = 1'b0;
        cnt_ch_d   = '0;
        cnt_ch_inc = cnt_ch_q + DW'(1);
        if (s_ch_q == ch_out_q || s_ch_q != s_ch_ant_q) begin
            cnt_ch_d = '0;
        end else if (cnt_ch_inc == DEB_LAST) begin
            ch_out_d   = s_ch_q;
            ch_mudou_d = 1'b1;
        end else begin
            cnt_ch_d = cnt_ch_inc;
        end
    end

    always_comb begin
        estado_d        = estado_q;
        cnt_b_d         = cnt_b_q;
        cnt_h_d         = cnt_h_q;
        longo_emitido_d = longo_emitido_q;
        cnt_b_inc       = cnt_b_q + DW'(1);
        case (estado_q)
            SOLTO: begin
                if (p) begin
                    estado_d = CONF_PRESS;
                    cnt_b_d  = '0;
                end
            end
            CONF_PRESS: begin
                if (!p) begin
                    estado_d = SOLTO;
                end else if (cnt_b_inc == DEB_LAST) begin
                    estado_d        = PRESSIONADO;
                    cnt_h_d         = '0;
                    longo_emitido_d = 1'b0;
                end else begin
                    cnt_b_d = cnt_b_inc;
                end
            end
            PRESSIONADO: begin
                // Release wins over reaching the long-press count.
                if (!p) begin
                    estado_d = CONF_SOLTA;
                    cnt_b_d  = '0;
                end else if (cnt_h_q == LONG_LAST) begin
                    estado_d        = LONGO;
                    longo_emitido_d = 1'b1;
                end else begin
                    cnt_h_d = cnt_h_q + HW'(1);
                end
            end
            LONGO: begin
                if (!p) begin
                    estado_d = CONF_SOLTA;
                    cnt_b_d  = '0;
                end
            end
            CONF_SOLTA: begin
                if (p) begin
                    estado_d = longo_emitido_q ? LONGO : PRESSIONADO;
                end else if (cnt_b_inc == DEB_LAST) begin
                    estado_d = SOLTO;
                end else begin
                    cnt_b_d = cnt_b_inc;
                end
            end
            default: estado_d = SOLTO;
        endcase
    end

    always_comb begin
        btn_pulso_d = (estado_q == CONF_PRESS) && (estado_d == PRESSIONADO);
        btn_longo_d = (estado_q == PRESSIONADO) && (estado_d == LONGO);
        btn_nivel_d = (estado_d == PRESSIONADO) || (estado_d == LONGO) ||
                      (estado_d == CONF_SOLTA);
    end

    assign ch_out    = ch_out_q;
    assign ch_mudou  = ch_mudou_q;
    assign btn_nivel = btn_nivel_q;
    assign btn_pulso = btn_pulso_q;
    assign btn_longo = btn_longo_q;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Scoreboard bench for condicionador_entradas with DEB_MAX=4, LONG_MAX=10:
// stimulus pushes expected event cycles, a negedge monitor pops and compares.
module tb_condicionador_entradas;

    localparam int DEB_MAX  = 4;
    localparam int LONG_MAX = 10;
    localparam int N_CH     = 8;

    logic            clock_in = 1'b0;
    logic            reset_n  = 1'b0;
    logic [N_CH-1:0] ch_raw   = '0;
    logic            btn_raw  = 1'b1;
    logic [N_CH-1:0] ch_out;
    logic            ch_mudou, btn_nivel, btn_pulso, btn_longo;

    condicionador_entradas #(
        .DEB_MAX (DEB_MAX),
        .LONG_MAX(LONG_MAX),
        .N_CH    (N_CH)
    ) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .ch_raw   (ch_raw),
        .btn_raw  (btn_raw),
        .ch_out   (ch_out),
        .ch_mudou (ch_mudou),
        .btn_nivel(btn_nivel),
        .btn_pulso(btn_pulso),
        .btn_longo(btn_longo)
    );

    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        logic [N_CH-1:0] val;
    } ev_ch_t;

    ev_ch_t q_ch[$];
    int     q_pulso[$];
    int     q_longo[$];
    ev_ch_t mon_ev;
    int     mon_c;

    int applied     = 0;
    int miscompares = 0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        applied++;
        if (atual !== esperado) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nome, atual, esperado, cyc);
        end
    endtask

    // Inputs change 1 time unit after the falling edge; cyc then counts the rising edges so far.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock_in);
            #1;
        end
    endtask

    always @(negedge clock_in) begin
        if (ch_mudou) begin
            check("ch_mudou expected", 32'(q_ch.size() > 0), 1);
            if (q_ch.size() > 0) begin
                mon_ev = q_ch.pop_front();
                check("ch_mudou cycle", cyc, mon_ev.cyc);
                check("ch_out value", 32'(ch_out), 32'(mon_ev.val));
            end
        end
        if (btn_pulso) begin
            check("btn_pulso expected", 32'(q_pulso.size() > 0), 1);
            if (q_pulso.size() > 0) begin
                mon_c = q_pulso.pop_front();
                check("btn_pulso cycle", cyc, mon_c);
            end
        end
        if (btn_longo) begin
            check("btn_longo expected", 32'(q_longo.size() > 0), 1);
            if (q_longo.size() > 0) begin
                mon_c = q_longo.pop_front();
                check("btn_longo cycle", cyc, mon_c);
            end
        end
    end

    int c0;

    initial begin
        // Power-on reset
        tick(3);
        check("reset ch_out", 32'(ch_out), 0);
        check("reset btn_nivel", 32'(btn_nivel), 0);
        reset_n = 1'b1;
        tick(8);

        // Switch glitch of 3 cycles is rejected
        ch_raw = 8'h05;
        tick(3);
        ch_raw = 8'h00;
        tick(10);
        check("glitch ch_out", 32'(ch_out), 0);

        // Stable 05 is accepted 6 edges after the first sampling edge
        c0 = cyc;
        ch_raw = 8'h05;
        q_ch.push_back('{cyc: c0 + 6, val: 8'h05});
        tick(5);
        check("ch_out before accept", 32'(ch_out), 0);
        tick(5);
        check("ch_out after accept", 32'(ch_out), 32'h05);

        // Bouncing press: 2-cycle lows never survive the debounce
        for (int k = 0; k < 20; k++) begin
            btn_raw = 1'((k / 2) % 2);
            tick(1);
        end
        check("bounce btn_nivel", 32'(btn_nivel), 0);
        c0 = cyc;
        btn_raw = 1'b0;
        q_pulso.push_back(c0 + 6);
        q_longo.push_back(c0 + 16);
        tick(5);
        check("btn_nivel before press", 32'(btn_nivel), 0);
        tick(1);
        check("btn_nivel at press", 32'(btn_nivel), 1);

        // Long press: single btn_longo at c0+16, none after while held
        tick(24);
        check("btn_nivel long hold", 32'(btn_nivel), 1);
        check("longo queue drained", q_longo.size(), 0);

        // Release bounce: 1,1,0,1... returns to LONGO, nivel falls 4 edges after sync
        c0 = cyc;
        btn_raw = 1'b1;
        tick(2);
        btn_raw = 1'b0;
        tick(1);
        btn_raw = 1'b1;
        tick(5);
        check("btn_nivel release pending", 32'(btn_nivel), 1);
        tick(1);
        check("btn_nivel released", 32'(btn_nivel), 0);
        tick(10);

        // Simultaneous switch change and press
        c0 = cyc;
        ch_raw  = 8'h3C;
        btn_raw = 1'b0;
        q_ch.push_back('{cyc: c0 + 6, val: 8'h3C});
        q_pulso.push_back(c0 + 6);
        q_longo.push_back(c0 + 16);
        tick(18);
        check("ch_out simultaneous", 32'(ch_out), 32'h3C);
        check("btn_nivel simultaneous", 32'(btn_nivel), 1);

        // Asynchronous reset mid-press aborts everything
        check("queues empty before reset", q_ch.size() + q_pulso.size() + q_longo.size(), 0);
        #2;
        reset_n = 1'b0;
        ch_raw  = 8'hFF;
        #1;
        check("async reset ch_out", 32'(ch_out), 0);
        check("async reset btn_nivel", 32'(btn_nivel), 0);
        check("async reset ch_mudou", 32'(ch_mudou), 0);
        check("async reset pulses", 32'({btn_pulso, btn_longo}), 0);
        tick(3);
        c0 = cyc;
        reset_n = 1'b1;
        q_ch.push_back('{cyc: c0 + 6, val: 8'hFF});
        q_pulso.push_back(c0 + 6);
        tick(5);
        check("ch_out before post-reset accept", 32'(ch_out), 0);
        tick(5);
        check("ch_out post-reset", 32'(ch_out), 32'hFF);
        btn_raw = 1'b1;
        tick(12);
        check("btn_nivel final", 32'(btn_nivel), 0);

        check("pending ch events", q_ch.size(), 0);
        check("pending pulso events", q_pulso.size(), 0);
        check("pending longo events", q_longo.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/condicionador_entradas.md
Name: condicionador_entradas

Overview:
- Input-conditioning stage directly upstream of the game top level.
- Takes the raw slide switches ch0..ch7 and the active-low push button btn0 from the board pins.
- Delivers synchronized, debounced switch levels plus clean single-cycle button events, so the preparation and attack logic never see metastable or bouncing inputs.
- Also provides a long-press event that the game uses to restart a match.

Parameters:
- DEB_MAX, 250000, cycles an input must be stable before it is accepted (5 ms at 50 MHz); minimum 2.
- LONG_MAX, 100000000, cycles the button must stay debounced-pressed before btn_longo fires (2 s at 50 MHz); minimum 2.
- N_CH, 8, number of switch inputs.

Ports:
- clock_in  input  1  system clock; every register is clocked on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- ch_raw  input  N_CH  raw switch pins; bit i is chi.
- btn_raw  input  1  raw btn0 pin; 0 means pressed.
- ch_out  output  N_CH  debounced switch vector.
- ch_mudou  output  1  one-cycle pulse when ch_out changes.
- btn_nivel  output  1  debounced button level; 1 means pressed.
- btn_pulso  output  1  one-cycle pulse on an accepted press.
- btn_longo  output  1  one-cycle pulse when LONG_MAX hold is reached.

Behaviour:
- Reset: clock_in and reset_n are the only clock and reset. Reset is asynchronous and active-low. While reset_n=0:
  - ch_out=0; ch_mudou, btn_nivel, btn_pulso, btn_longo all 0.
  - Switch synchronizer flops are 0; button synchronizer flops are 1 (released).
  - All counters are 0; the FSM is in SOLTO.
- Reset mid-operation aborts any debounce or hold in progress immediately.
- Synchronizer: 2-flop chain on every input. Call the synchronized values s_ch and s_btn, and define p = ~s_btn.
- Switch debounce (one shared counter cnt_ch, width clog2(DEB_MAX)):
  - If s_ch equals ch_out, cnt_ch=0.
  - If s_ch differs from ch_out and also differs from its value on the previous cycle, cnt_ch restarts at 0.
  - Otherwise cnt_ch increments.
  - When cnt_ch==DEB_MAX-1 on a clock edge: ch_out<=s_ch, ch_mudou=1 for that one cycle, cnt_ch<=0.
  - Latency: a raw change held stable appears on ch_out exactly 2+DEB_MAX edges after the first edge that samples it.
  - Glitches shorter than DEB_MAX cycles produce no ch_out change.
- Button FSM, with a debounce counter cnt_b and a hold counter cnt_h (width clog2(LONG_MAX)):
  - SOLTO: if p, go to CONF_PRESS with cnt_b=0.
  - CONF_PRESS:
    - If !p, go to SOLTO.
    - Else cnt_b++.
    - When cnt_b==DEB_MAX-1: go to PRESSIONADO, btn_pulso=1 for one cycle, cnt_h=0, longo_emitido=0.
  - PRESSIONADO:
    - cnt_h++.
    - When cnt_h==LONG_MAX-1: go to LONGO, btn_longo=1 for one cycle, longo_emitido=1.
    - If !p, go to CONF_SOLTA with cnt_b=0. Release takes priority over reaching LONG_MAX on the same cycle.
  - LONGO: if !p, go to CONF_SOLTA with cnt_b=0. No further btn_longo pulses are produced.
  - CONF_SOLTA:
    - cnt_h is frozen.
    - If p, return to LONGO when longo_emitido=1, else to PRESSIONADO. No btn_pulso is produced on this return.
    - Else cnt_b++; when cnt_b==DEB_MAX-1, go to SOLTO.
- btn_nivel=1 in PRESSIONADO, LONGO and CONF_SOLTA; 0 otherwise.
- Outputs are registered: btn_pulso rises on the same edge that enters PRESSIONADO.
- btn_pulso and btn_longo can never be asserted on the same cycle. At most one btn_pulso and one btn_longo are produced per physical press.
- Switch and button paths are independent; simultaneous events on both are handled in parallel.

Test Plan (DEB_MAX=4, LONG_MAX=10 for simulation):
1. Reset: assert reset_n=0 mid-press with ch_raw=8'hFF → all outputs 0 asynchronously. Release reset → ch_out=8'hFF exactly 6 edges later, with ch_mudou high for 1 cycle.
2. Switch glitch: ch_raw 8'h00→8'h05 for 3 cycles then back → ch_out stays 00 and ch_mudou never fires. Hold 8'h05 for 4+ cycles → ch_out=05 at edge 6.
3. Bouncing press: btn_raw toggles 0/1 every 2 cycles for 20 cycles, then holds 0 → exactly one btn_pulso, 6 edges after the hold starts; btn_nivel=1 from that edge.
4. Long press: hold btn_raw=0 → btn_pulso at edge 6, btn_longo at edge 16, and no second btn_longo while still held.
5. Release bounce: after the long press, btn_raw=1 for 2 cycles, 0 for 1 cycle, then 1 → state returns to LONGO without a new pulse; btn_nivel falls 4 edges after the final release is synchronized.
6. Simultaneous: change ch_raw to 8'h3C on the same cycle btn_raw goes to 0 → ch_mudou and btn_pulso both fire at edge 6, ch_out=3C.
